ym_turbo: RTL and testbench

Multi-chip OPN controller for the sound subsystem: a parametrised successor to the single-chip YM2203 wrapper that fronts NUM_CHIPS YM2203-class chips (each an FM core plus a PSG core instantiated outside this block). It decodes TurboSound-style chip selection, steers CPU writes and reads to the selected chip, and snoops each chip's prescaler registers. From the master clock enable it generates per-chip FM/PSG clock enables, and it produces a saturated mono mix of all chips' outputs with a time-multiplexed accumulator.

---
 rtl/ym_turbo_pkg.sv | 19 +
 rtl/ym_ce_div.sv | 34 +++
 rtl/ym_turbo.sv | 143 ++++++++++++++
 tb/tb_ym_turbo.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/ym_turbo_pkg.sv
// Shared constants, prescaler tables and mixer state type for the ym_turbo multi-chip OPN controller.
package ym_turbo_pkg;
  localparam int FM_W  = 11;
  localparam int PSG_W = 8;
  localparam int SLOTS = 4;

  localparam logic [7:0] SEL_CMD_BASE = 8'hFF;
  localparam logic [7:0] SEL_CMD_MIN  = 8'hFC;

  localparam logic [7:0] REG_PRES_SET1 = 8'h2D;
  localparam logic [7:0] REG_PRES_SET0 = 8'h2E;
  localparam logic [7:0] REG_PRES_CLR  = 8'h2F;

  // Divider terminal counts indexed by pres; entry [0] is pres=0.
  localparam logic [3:0][2:0] OPN_LIMIT = {3'd2, 3'd5, 3'd1, 3'd1};
  localparam logic [3:0][1:0] PSG_LIMIT = {2'd1, 2'd3, 2'd0, 2'd0};

  typedef enum logic [1:0] {MIX_IDLE, MIX_ACC, MIX_DONE} mix_state_t;
endpackage

// File: rtl/ym_ce_div.sv
// Per-chip FM/PSG clock-enable divider driven by the master CE_YM and the snooped prescaler.
module ym_ce_div
  import ym_turbo_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       CE_YM,
  input  logic [1:0] pres,
  output logic       ce_opn,
  output logic       ce_psg
);
  logic [2:0] div_opn, lim_opn;
  logic [1:0] div_psg, lim_psg;

  assign lim_opn = OPN_LIMIT[pres];
  assign lim_psg = PSG_LIMIT[pres];

  // >= rather than == so a prescaler shrink mid-count wraps instead of running long.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      div_opn <= '0;
      div_psg <= '0;
      ce_opn  <= 1'b0;
      ce_psg  <= 1'b0;
    end else begin
      ce_opn <= CE_YM && (div_opn == 3'd0);
      ce_psg <= CE_YM && (div_psg == 2'd0);
      if (CE_YM) begin
        div_opn <= (div_opn >= lim_opn) ? 3'd0 : div_opn + 3'd1;
        div_psg <= (div_psg >= lim_psg) ? 2'd0 : div_psg + 2'd1;
      end
    end
  end
endmodule

// File: rtl/ym_turbo.sv
// Multi-chip OPN controller: TurboSound chip select, write/read steering, prescaler snoop, CE generation.
// Define YM_TURBO_MIX_EN to build the time-multiplexed saturating mono mixer; otherwise MIX/MIX_STB are 0.
module ym_turbo
  import ym_turbo_pkg::*;
#(
  parameter int NUM_CHIPS = 2,
  parameter int MIX_W     = 16,
  localparam int CW       = (NUM_CHIPS > 1) ? $clog2(NUM_CHIPS) : 1
) (
  input  logic                         CLK,
  input  logic                         RESET_N,
  input  logic                         CE_CPU,
  input  logic                         CE_YM,
  input  logic                         A0,
  input  logic                         WE,
  input  logic [7:0]                   DI,
  output logic [7:0]                   DO,
  input  logic                         FM_ENA,
  output logic [CW-1:0]                CHIP_SEL,
  output logic [NUM_CHIPS-1:0]         CHIP_WE,
  input  logic [8*NUM_CHIPS-1:0]       CHIP_DO,
  output logic [NUM_CHIPS-1:0]         CE_OPN,
  output logic [NUM_CHIPS-1:0]         CE_PSG,
  input  logic [FM_W*NUM_CHIPS-1:0]    FM_IN,
  input  logic [3*PSG_W*NUM_CHIPS-1:0] PSG_IN,
  output logic [MIX_W-1:0]             MIX,
  output logic                         MIX_STB
);
  logic                          sel_cmd;
  logic [NUM_CHIPS-1:0][7:0]     reg_idx;
  logic [NUM_CHIPS-1:0][1:0]     pres;
  logic [NUM_CHIPS-1:0][7:0]     chip_do_a;

  assign sel_cmd   = CE_CPU && WE && !A0 && (DI >= SEL_CMD_MIN);
  assign chip_do_a = CHIP_DO;
  assign DO        = chip_do_a[CHIP_SEL];

  always_comb begin
    CHIP_WE = '0;
    if (!sel_cmd) CHIP_WE[CHIP_SEL] = WE;
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      CHIP_SEL <= '0;
      reg_idx  <= '0;
      pres     <= {NUM_CHIPS{2'b10}};
    end else if (CE_CPU && WE) begin
      if (sel_cmd) begin
        // Select codes beyond the populated chips are swallowed without effect.
        if ((SEL_CMD_BASE - DI) < 8'(NUM_CHIPS)) CHIP_SEL <= CW'(SEL_CMD_BASE - DI);
      end else if (!A0) begin
        reg_idx[CHIP_SEL] <= DI;
      end else if (FM_ENA) begin
        case (reg_idx[CHIP_SEL])
          REG_PRES_SET1: pres[CHIP_SEL][1] <= 1'b1;
          REG_PRES_SET0: pres[CHIP_SEL][0] <= 1'b1;
          REG_PRES_CLR:  pres[CHIP_SEL]    <= 2'b00;
          default: ;
        endcase
      end
    end
  end

  for (genvar g = 0; g < NUM_CHIPS; g++) begin : g_div
    ym_ce_div u_div (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .CE_YM   (CE_YM),
      .pres    (pres[g]),
      .ce_opn  (CE_OPN[g]),
      .ce_psg  (CE_PSG[g])
    );
  end

`ifdef YM_TURBO_MIX_EN
  localparam int NSLOT = SLOTS * NUM_CHIPS;
  localparam int IW    = $clog2(NSLOT);
  localparam int AW    = MIX_W + 1;

  mix_state_t                               state, state_nx;
  logic [AW-1:0]                            acc;
  logic [IW-1:0]                            idx;
  logic [CW-1:0]                            mchip;
  logic [1:0]                               mslot;
  logic [FM_W-1:0]                          addend;
  logic [NUM_CHIPS-1:0][FM_W-1:0]           fm_a;
  logic [NUM_CHIPS-1:0][2:0][PSG_W-1:0]     psg_a;

  assign fm_a   = FM_IN;
  assign psg_a  = PSG_IN;
  assign mchip  = CW'(idx >> 2);
  assign mslot  = idx[1:0];
  // Slots 0..2 are PSG A/B/C, slot 3 is the FM output of the same chip.
  assign addend = (mslot == 2'd3) ? fm_a[mchip] : FM_W'(psg_a[mchip][mslot]);

  always_ff @(posedge CLK) begin
    if (!RESET_N) state <= MIX_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      MIX_IDLE: if (CE_YM) state_nx = MIX_ACC;
      MIX_ACC:  if (idx == IW'(NSLOT - 1)) state_nx = MIX_DONE;
      MIX_DONE: state_nx = MIX_IDLE;
      default:  state_nx = MIX_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      acc     <= '0;
      idx     <= '0;
      MIX     <= '0;
      MIX_STB <= 1'b0;
    end else begin
      MIX_STB <= 1'b0;
      case (state)
        MIX_IDLE: if (CE_YM) begin
          acc <= '0;
          idx <= '0;
        end
        MIX_ACC: begin
          acc <= acc + AW'(addend);
          idx <= idx + IW'(1);
        end
        MIX_DONE: begin
          MIX     <= acc[MIX_W] ? {MIX_W{1'b1}} : acc[MIX_W-1:0];
          MIX_STB <= 1'b1;
        end
        default: ;
      endcase
    end
  end
`else
  logic unused_mix_in;
  assign unused_mix_in = ^{FM_IN, PSG_IN};
  assign MIX     = '0;
  assign MIX_STB = 1'b0;
`endif
endmodule

// File: tb/tb_ym_turbo.sv
// Directed bench for ym_turbo: a 2-chip/16-bit instance and a 4-chip/14-bit instance share the CPU side.
module tb_ym_turbo;
  logic CLK, RESET_N, CE_CPU, CE_YM, A0, WE, FM_ENA;
  logic [7:0] DI;

  logic [7:0]  do0;   logic [0:0] sel0;  logic [1:0] we0;
  logic [15:0] cdo0;  logic [1:0] opn0;  logic [1:0] psg0;
  logic [21:0] fm0;   logic [47:0] pin0; logic [15:0] mix0; logic stb0;

  logic [7:0]  do1;   logic [1:0] sel1;  logic [3:0] we1;
  logic [31:0] cdo1;  logic [3:0] opn1;  logic [3:0] psg1;
  logic [43:0] fm1;   logic [95:0] pin1; logic [13:0] mix1; logic stb1;

  int checks = 0;
  int errors = 0;

  ym_turbo #(.NUM_CHIPS(2), .MIX_W(16)) dut0 (
    .CLK(CLK), .RESET_N(RESET_N), .CE_CPU(CE_CPU), .CE_YM(CE_YM), .A0(A0), .WE(WE),
    .DI(DI), .DO(do0), .FM_ENA(FM_ENA), .CHIP_SEL(sel0), .CHIP_WE(we0), .CHIP_DO(cdo0),
    .CE_OPN(opn0), .CE_PSG(psg0), .FM_IN(fm0), .PSG_IN(pin0), .MIX(mix0), .MIX_STB(stb0));

  ym_turbo #(.NUM_CHIPS(4), .MIX_W(14)) dut1 (
    .CLK(CLK), .RESET_N(RESET_N), .CE_CPU(CE_CPU), .CE_YM(CE_YM), .A0(A0), .WE(WE),
    .DI(DI), .DO(do1), .FM_ENA(FM_ENA), .CHIP_SEL(sel1), .CHIP_WE(we1), .CHIP_DO(cdo1),
    .CE_OPN(opn1), .CE_PSG(psg1), .FM_IN(fm1), .PSG_IN(pin1), .MIX(mix1), .MIX_STB(stb1));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK); #1;
  endtask

  task automatic idle_cpu;
    CE_CPU = 1'b0; WE = 1'b0; A0 = 1'b0; DI = 8'h00; FM_ENA = 1'b0;
  endtask

  // Presents a CPU write and settles; the caller checks CHIP_WE, then ticks.
  task automatic drive_wr(input logic a0, input logic [7:0] d, input logic fe);
    CE_CPU = 1'b1; WE = 1'b1; A0 = a0; DI = d; FM_ENA = fe;
    #1;
  endtask

  task automatic finish_wr;
    tick; idle_cpu;
  endtask

  // Free-runs CE_YM every 2nd CLK and reports min/max pulse spacing of one dut0 chip.
  task automatic measure(input int chip, output int omin, output int omax,
                         output int pmin, output int pmax);
    int lo_o, lo_p;
    lo_o = -1; lo_p = -1; omin = 999; omax = 0; pmin = 999; pmax = 0;
    for (int c = 0; c < 64; c++) begin
      CE_YM = (c % 2 == 0);
      tick;
      if (c >= 16 && opn0[chip]) begin
        if (lo_o >= 0) begin
          if (c - lo_o < omin) omin = c - lo_o;
          if (c - lo_o > omax) omax = c - lo_o;
        end
        lo_o = c;
      end
      if (c >= 16 && psg0[chip]) begin
        if (lo_p >= 0) begin
          if (c - lo_p < pmin) pmin = c - lo_p;
          if (c - lo_p > pmax) pmax = c - lo_p;
        end
        lo_p = c;
      end
    end
    CE_YM = 1'b0;
  endtask

  task automatic test_reset;
    RESET_N = 1'b0; CE_YM = 1'b0; idle_cpu;
    tick; tick;
    checks++; if (sel0 !== 1'b0) begin errors++; $display("FAIL reset_sel0 got %0d exp 0", sel0); end
    checks++; if (sel1 !== 2'd0) begin errors++; $display("FAIL reset_sel1 got %0d exp 0", sel1); end
    checks++; if (opn0 !== 2'b00 || psg0 !== 2'b00) begin errors++; $display("FAIL reset_ce got %b/%b exp 00/00", opn0, psg0); end
    checks++; if (mix0 !== 16'd0 || stb0 !== 1'b0) begin errors++; $display("FAIL reset_mix got %0d/%b exp 0/0", mix0, stb0); end
    checks++; if (do0 !== 8'hA0) begin errors++; $display("FAIL reset_do got %h exp a0", do0); end
    RESET_N = 1'b1;
    tick;
  endtask

  task automatic test_ce_rate;
    int omin, omax, pmin, pmax;
    for (int ch = 0; ch < 2; ch++) begin
      measure(ch, omin, omax, pmin, pmax);
      checks++; if (omin != 12 || omax != 12) begin errors++; $display("FAIL rate_opn%0d got %0d..%0d exp 12", ch, omin, omax); end
      checks++; if (pmin != 8 || pmax != 8) begin errors++; $display("FAIL rate_psg%0d got %0d..%0d exp 8", ch, pmin, pmax); end
    end
  endtask

  task automatic test_select;
    int omin, omax, pmin, pmax;
    drive_wr(1'b0, 8'hFE, 1'b1);
    checks++; if (we0 !== 2'b00 || we1 !== 4'b0000) begin errors++; $display("FAIL sel_fe_we got %b/%b exp 00/0000", we0, we1); end
    finish_wr;
    checks++; if (sel0 !== 1'b1 || sel1 !== 2'd1) begin errors++; $display("FAIL sel_fe got %0d/%0d exp 1/1", sel0, sel1); end
    checks++; if (do0 !== 8'hB1) begin errors++; $display("FAIL read_chip1 got %h exp b1", do0); end
    drive_wr(1'b0, 8'h2F, 1'b1);
    checks++; if (we0 !== 2'b10) begin errors++; $display("FAIL addr_we got %b exp 10", we0); end
    finish_wr;
    drive_wr(1'b1, 8'h00, 1'b1);
    checks++; if (we0 !== 2'b10) begin errors++; $display("FAIL data_we got %b exp 10", we0); end
    finish_wr;
    measure(1, omin, omax, pmin, pmax);
    checks++; if (omin != 4 || omax != 4) begin errors++; $display("FAIL pres0_opn1 got %0d..%0d exp 4", omin, omax); end
    checks++; if (pmin != 2 || pmax != 2) begin errors++; $display("FAIL pres0_psg1 got %0d..%0d exp 2", pmin, pmax); end
    measure(0, omin, omax, pmin, pmax);
    checks++; if (omin != 12 || omax != 12) begin errors++; $display("FAIL keep_opn0 got %0d..%0d exp 12", omin, omax); end
    checks++; if (pmin != 8 || pmax != 8) begin errors++; $display("FAIL keep_psg0 got %0d..%0d exp 8", pmin, pmax); end
  endtask

  task automatic test_bad_select;
    int omin, omax, pmin, pmax;
    drive_wr(1'b0, 8'hFC, 1'b1);
    checks++; if (we0 !== 2'b00 || we1 !== 4'b0000) begin errors++; $display("FAIL sel_fc_we got %b/%b exp 00/0000", we0, we1); end
    finish_wr;
    checks++; if (sel0 !== 1'b1) begin errors++; $display("FAIL sel_fc_2chip got %0d exp 1", sel0); end
    checks++; if (sel1 !== 2'd3) begin errors++; $display("FAIL sel_fc_4chip got %0d exp 3", sel1); end
    drive_wr(1'b0, 8'h2D, 1'b0);
    finish_wr;
    drive_wr(1'b1, 8'h00, 1'b0);
    finish_wr;
    measure(1, omin, omax, pmin, pmax);
    checks++; if (omin != 4 || omax != 4 || pmin != 2 || pmax != 2) begin
      errors++; $display("FAIL snoop_fmena0 got opn %0d..%0d psg %0d..%0d exp 4/2", omin, omax, pmin, pmax); end
  endtask

  task automatic test_wrap;
    logic found;
    drive_wr(1'b0, 8'hFF, 1'b1);
    finish_wr;
    checks++; if (sel0 !== 1'b0) begin errors++; $display("FAIL sel_ff got %0d exp 0", sel0); end
    drive_wr(1'b0, 8'h2F, 1'b1);
    finish_wr;
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      CE_YM = 1'b1; tick; CE_YM = 1'b0;
      if (opn0[0]) found = 1'b1;
      else tick;
    end
    checks++; if (!found) begin errors++; $display("FAIL wrap_sync got no pulse exp pulse within 20 CE_YM"); end
    // three more CE_YM leave the chip0 OPN divider at 4
    for (int n = 0; n < 3; n++) begin
      tick; CE_YM = 1'b1; tick; CE_YM = 1'b0;
    end
    drive_wr(1'b1, 8'h00, 1'b1);
    finish_wr;
    for (int j = 0; j < 6; j++) begin
      CE_YM = 1'b1; tick; CE_YM = 1'b0;
      checks++; if (opn0[0] !== (j % 2 == 1)) begin errors++; $display("FAIL wrap_seq%0d got %b exp %b", j, opn0[0], (j % 2 == 1)); end
      tick;
      checks++; if (opn0[0] !== 1'b0) begin errors++; $display("FAIL wrap_gap%0d got %b exp 0", j, opn0[0]); end
    end
  endtask

  // Fires one CE_YM and returns the CLK count to each MIX_STB (-1 if none) and the strobe count.
  task automatic sweep(output int lat0, output int lat1, output int nstb0, output int nstb1);
    lat0 = -1; lat1 = -1; nstb0 = 0; nstb1 = 0;
    CE_YM = 1'b1; tick; CE_YM = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      tick;
      if (stb0) begin nstb0++; if (lat0 < 0) lat0 = n; end
      if (stb1) begin nstb1++; if (lat1 < 0) lat1 = n; end
    end
  endtask

  task automatic test_mix;
    int lat0, lat1, n0, n1;
    fm0  = {11'd1000, 11'd100};
    pin0 = {8'd30, 8'd20, 8'd10, 8'd3, 8'd2, 8'd1};
    fm1  = '1;
    pin1 = '1;
    CE_YM = 1'b0;
    for (int n = 0; n < 20; n++) tick;
    sweep(lat0, lat1, n0, n1);
`ifdef YM_TURBO_MIX_EN
    checks++; if (lat0 != 9 || n0 != 1) begin errors++; $display("FAIL mix2_stb got lat %0d cnt %0d exp 9/1", lat0, n0); end
    checks++; if (mix0 !== 16'd1166) begin errors++; $display("FAIL mix2_val got %0d exp 1166", mix0); end
    checks++; if (lat1 != 17 || n1 != 1) begin errors++; $display("FAIL mix4_stb got lat %0d cnt %0d exp 17/1", lat1, n1); end
    checks++; if (mix1 !== 14'd11248) begin errors++; $display("FAIL mix4_val got %0d exp 11248", mix1); end
`else
    checks++; if (n0 != 0 || n1 != 0) begin errors++; $display("FAIL nomix_stb got %0d/%0d exp 0/0", n0, n1); end
    checks++; if (mix0 !== 16'd0 || mix1 !== 14'd0) begin errors++; $display("FAIL nomix_val got %0d/%0d exp 0/0", mix0, mix1); end
`endif
  endtask

  task automatic test_reset_mid_sweep;
    int lat0, lat1, n0, n1;
    CE_YM = 1'b1; tick; CE_YM = 1'b0;
    tick; tick; tick;
    RESET_N = 1'b0; tick; RESET_N = 1'b1;
    n0 = 0;
    for (int n = 0; n < 30; n++) begin
      tick;
      if (stb0) n0++;
    end
    checks++; if (n0 != 0) begin errors++; $display("FAIL abort_stb got %0d exp 0", n0); end
    checks++; if (mix0 !== 16'd0) begin errors++; $display("FAIL abort_mix got %0d exp 0", mix0); end
    sweep(lat0, lat1, n0, n1);
`ifdef YM_TURBO_MIX_EN
    checks++; if (lat0 != 9 || mix0 !== 16'd1166) begin errors++; $display("FAIL resweep got lat %0d mix %0d exp 9/1166", lat0, mix0); end
`else
    checks++; if (n0 != 0 || mix0 !== 16'd0) begin errors++; $display("FAIL resweep_off got %0d/%0d exp 0/0", n0, mix0); end
`endif
  endtask

  initial begin
    CE_YM = 1'b0; RESET_N = 1'b0; idle_cpu;
    cdo0 = {8'hB1, 8'hA0};
    cdo1 = {8'hD3, 8'hC2, 8'hC1, 8'hC0};
    fm0 = '0; pin0 = '0; fm1 = '0; pin1 = '0;
    test_reset;
    test_ce_rate;
    test_select;
    test_bad_select;
    test_wrap;
    test_mix;
    test_reset_mid_sweep;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1);
  end
endmodule
